sram_sdp: RTL and testbench
===========================

SRAM_SDP -- requirements
Module: sram_sdp

Interface
REQ-001 The block SHALL take parameter ADDR_WIDTH, default 8, address bits per port.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 8, word width; an integer multiple of BYTE_WIDTH.
REQ-003 The block SHALL take parameter BYTE_WIDTH, default 8, width of one write-enable lane.
REQ-004 The block SHALL take parameter DEPTH, default 256, words stored; DEPTH <= 2**ADDR_WIDTH.
REQ-005 The block SHALL take parameter MEMFILE, default "", hex init file; empty means no load.
REQ-006 The block SHALL take parameter OUT_REG, default 0, 1 adds one output pipeline stage.
REQ-007 The block SHALL take parameter RDW_MODE, default 0, same-address read-during-write: 0 old data, 1 new data.
REQ-008 Port i_clk, input, 1, sole clock; all logic on the rising edge.
REQ-009 Port i_rst_n, input, 1, asynchronous active-low reset.
REQ-010 Port i_we, input, 1, write request.
REQ-011 Port i_waddr, input, ADDR_WIDTH, write address.
REQ-012 Port i_wdata, input, DATA_WIDTH, write data.
REQ-013 Port i_wbe, input, DATA_WIDTH/BYTE_WIDTH, per-lane write enable; bit n covers lane n, LSB lane first.
REQ-014 Port i_re, input, 1, read request.
REQ-015 Port i_raddr, input, ADDR_WIDTH, read address.
REQ-016 Port o_rdata, output, DATA_WIDTH, read data.
REQ-017 Port o_rvalid, output, 1, one-cycle pulse marking o_rdata valid.
REQ-018 Port o_ready, output, 1, high when the block accepts requests.

Function
REQ-019 A write SHALL be accepted when i_we and o_ready are both high; only lanes with i_wbe set are updated.
REQ-020 A read accepted at edge N (i_re and o_ready high) SHALL present o_rdata with o_rvalid high after edge N+1+OUT_REG.
REQ-021 Back-to-back reads SHALL sustain one per cycle; o_rvalid SHALL be high for exactly one cycle per accepted read.
REQ-022 o_rdata SHALL hold its last value when no read completes.
REQ-023 With i_we and i_re both high in one cycle to the same address, RDW_MODE=0 SHALL return pre-write data, and RDW_MODE=1 SHALL return the merged word (enabled lanes from i_wdata, others from old data).
REQ-024 A write with address >= DEPTH SHALL be dropped; a read with address >= DEPTH SHALL complete normally with o_rdata all zero.
REQ-025 Requests presented while o_ready is low SHALL be ignored, with no memory change and no o_rvalid.
REQ-026 A write with i_wbe all zero SHALL leave memory unchanged.

Reset
REQ-027 While i_rst_n is low: o_rdata = 0, o_rvalid = 0, o_ready = 0, pipeline stage cleared, clear counter = 0.
REQ-028 Memory contents SHALL NOT be reset by i_rst_n.
REQ-029 Reset asserted mid-read SHALL discard the in-flight read; no o_rvalid SHALL follow deassertion for it.

Configuration
REQ-030 With macro SRAM_SDP_CLEAR_EN defined, a clear engine SHALL be compiled in, with states CLEAR and READY.
REQ-031 With SRAM_SDP_CLEAR_EN defined, the engine SHALL enter CLEAR on reset release and write zero to addresses 0..DEPTH-1, one per cycle, in ascending order.
REQ-032 With SRAM_SDP_CLEAR_EN defined, the engine SHALL go CLEAR->READY after address DEPTH-1 is written, asserting o_ready on the next edge (DEPTH+1 edges after release); it SHALL overwrite MEMFILE contents.
REQ-033 With SRAM_SDP_CLEAR_EN defined, reset during CLEAR SHALL restart the sweep from address 0.
REQ-034 Without SRAM_SDP_CLEAR_EN, there SHALL be no engine; o_ready SHALL rise on the first edge after reset release and stay high; MEMFILE contents SHALL be preserved.

Structure
REQ-035 Package sram_pkg SHALL hold the RDW_OLD/RDW_NEW constants and the clear-engine state enum {CLEAR, READY}.
REQ-036 The clear engine SHALL be a sub-module named sram_clear, outputting the sweep address, the write strobe and done.
REQ-037 The memory array SHALL be inferred as block RAM, with a single write site and a single read site.

Verification
REQ-038 DATA_WIDTH=16: write addr 5 = 0xBEEF with i_wbe=2'b11, then write 0x1234 with i_wbe=2'b01, then read addr 5 -> 0xBE34.
REQ-039 OUT_REG=0 vs 1: read addr 3 at edge N -> o_rvalid at N+1 vs N+2, single pulse; 4 consecutive reads -> 4 consecutive valids.
REQ-040 Same-address write 0xAA over 0x55 with read in the same cycle -> 0x55 for RDW_MODE=0, 0xAA for RDW_MODE=1.
REQ-041 DEPTH=200: write 0x77 to addr 210 -> dropped; read addr 210 -> o_rdata 0x00 with o_rvalid.
REQ-042 CLEAR_EN, DEPTH=256: o_ready rises 257 edges after release; read at edge 100 ignored; reset at edge 50 then re-release -> 257 more edges; all words read 0.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared read-during-write constants and the clear-engine state type
// used across the simple dual-port SRAM.
package sram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clear_state_t;

endpackage

// File: rtl/sram_clear.sv
// Post-reset clear engine: sweeps addresses 0..DEPTH-1 in ascending order,
// writing one zero word per cycle, then reports done.
//
//   state | meaning
//   CLEAR | sweeping; o_we high, o_addr is the word being zeroed
//   READY | sweep finished; o_done high until the next reset
module sram_clear
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_we,
  output logic                  o_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  clear_state_t          state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= CLEAR;
      addr_q <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    o_we      = 1'b0;
    o_done    = 1'b0;
    case (state)
      CLEAR: begin
        o_we = 1'b1;
        if (addr_q == LAST) state_nxt = READY;
        else                addr_nxt  = addr_q + 1'b1;
      end
      READY:   o_done = 1'b1;
      default: state_nxt = CLEAR;
    endcase
  end

  assign o_addr = addr_q;

endmodule

// File: rtl/sram_sdp.sv
// Simple dual-port SRAM: byte-lane write port, pipelined read port.
// Define SRAM_SDP_CLEAR_EN to zero the whole array after every reset release.
module sram_sdp
  import sram_pkg::*;
#(
  parameter int    ADDR_WIDTH = 8,
  parameter int    DATA_WIDTH = 8,
  parameter int    BYTE_WIDTH = 8,
  parameter int    DEPTH      = 256,
  parameter string MEMFILE    = "",
  parameter int    OUT_REG    = 0,
  parameter int    RDW_MODE   = 0
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_we,
  input  logic [ADDR_WIDTH-1:0]            i_waddr,
  input  logic [DATA_WIDTH-1:0]            i_wdata,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_wbe,
  input  logic                             i_re,
  input  logic [ADDR_WIDTH-1:0]            i_raddr,
  output logic [DATA_WIDTH-1:0]            o_rdata,
  output logic                             o_rvalid,
  output logic                             o_ready
);

  localparam int                    LANES     = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  function automatic logic [DATA_WIDTH-1:0] lane_merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [LANES-1:0]      be
  );
    logic [DATA_WIDTH-1:0] w;
    w = old_word;
    for (int l = 0; l < LANES; l++)
      if (be[l]) w[l*BYTE_WIDTH +: BYTE_WIDTH] = new_word[l*BYTE_WIDTH +: BYTE_WIDTH];
    return w;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  ready_q, done;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

`ifdef SRAM_SDP_CLEAR_EN
  sram_clear #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_clear (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_addr  (clr_addr),
    .o_we    (clr_we),
    .o_done  (done)
  );
`else
  assign clr_addr = '0;
  assign clr_we   = 1'b0;
  assign done     = 1'b1;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ready_q <= 1'b0;
    else          ready_q <= done;
  end

  assign o_ready = ready_q;

  logic w_in, r_in, wr_acc, rd_acc;
  assign w_in   = {1'b0, i_waddr} < DEPTH_LIM;
  assign r_in   = {1'b0, i_raddr} < DEPTH_LIM;
  assign wr_acc = i_we & ready_q & w_in;
  assign rd_acc = i_re & ready_q;

  // The clear sweep only runs while o_ready is low, so it never races a user write.
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [LANES-1:0]      wr_be;
  assign wr_en   = clr_we | wr_acc;
  assign wr_addr = clr_we ? clr_addr : i_waddr;
  assign wr_data = clr_we ? '0 : i_wdata;
  assign wr_be   = clr_we ? '1 : i_wbe;

  always_ff @(posedge i_clk) begin
    if (wr_en)
      for (int l = 0; l < LANES; l++)
        if (wr_be[l]) mem[wr_addr][l*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[l*BYTE_WIDTH +: BYTE_WIDTH];
  end

  logic [DATA_WIDTH-1:0] mem_q;
  always_ff @(posedge i_clk) begin
    if (rd_acc && r_in) mem_q <= mem[i_raddr];
  end

  logic                  p_valid, p_oor, p_byp;
  logic [DATA_WIDTH-1:0] p_wdata;
  logic [LANES-1:0]      p_wbe;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p_valid <= 1'b0;
      p_oor   <= 1'b0;
      p_byp   <= 1'b0;
      p_wdata <= '0;
      p_wbe   <= '0;
    end else begin
      p_valid <= rd_acc;
      if (rd_acc) begin
        p_oor   <= !r_in;
        p_byp   <= (RDW_MODE == RDW_NEW) && wr_acc && (i_waddr == i_raddr);
        p_wdata <= i_wdata;
        p_wbe   <= i_wbe;
      end
    end
  end

  // mem_q holds pre-write data; new-data mode patches in the colliding lanes.
  logic [DATA_WIDTH-1:0] rd_word;
  always_comb begin
    rd_word = mem_q;
    if (p_oor)      rd_word = '0;
    else if (p_byp) rd_word = lane_merge(mem_q, p_wdata, p_wbe);
  end

  logic [DATA_WIDTH-1:0] rdata1;
  logic                  rvalid1;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata1  <= '0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid1 <= p_valid;
      if (p_valid) rdata1 <= rd_word;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] rdata2;
    logic                  rvalid2;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        rdata2  <= '0;
        rvalid2 <= 1'b0;
      end else begin
        rvalid2 <= rvalid1;
        if (rvalid1) rdata2 <= rdata1;
      end
    end
    assign o_rdata  = rdata2;
    assign o_rvalid = rvalid2;
  end else begin : g_noreg
    assign o_rdata  = rdata1;
    assign o_rvalid = rvalid1;
  end

endmodule

// File: tb/tb_sram_sdp.sv
// Directed bench for sram_sdp: two instances share stimulus, one with
// DEPTH=200/no output stage/old-data RDW, one with DEPTH=256/output stage/new-data RDW.
module tb_sram_sdp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we, re;
  logic [7:0]  waddr, raddr;
  logic [15:0] wdata;
  logic [1:0]  wbe;

  logic [15:0] a_rdata, b_rdata;
  logic        a_rvalid, a_ready, b_rvalid, b_ready;

  int n_cmp = 0;
  int n_err = 0;

`ifdef SRAM_SDP_CLEAR_EN
  localparam int READY_A = 201;
  localparam int READY_B = 257;
`else
  localparam int READY_A = 1;
  localparam int READY_B = 1;
`endif

  sram_sdp #(
    .ADDR_WIDTH (8), .DATA_WIDTH (16), .BYTE_WIDTH (8), .DEPTH (200),
    .MEMFILE (""), .OUT_REG (0), .RDW_MODE (0)
  ) u_a (
    .i_clk (clk), .i_rst_n (rst_n), .i_we (we), .i_waddr (waddr),
    .i_wdata (wdata), .i_wbe (wbe), .i_re (re), .i_raddr (raddr),
    .o_rdata (a_rdata), .o_rvalid (a_rvalid), .o_ready (a_ready)
  );

  sram_sdp #(
    .ADDR_WIDTH (8), .DATA_WIDTH (16), .BYTE_WIDTH (8), .DEPTH (256),
    .MEMFILE (""), .OUT_REG (1), .RDW_MODE (1)
  ) u_b (
    .i_clk (clk), .i_rst_n (rst_n), .i_we (we), .i_waddr (waddr),
    .i_wdata (wdata), .i_wbe (wbe), .i_re (re), .i_raddr (raddr),
    .o_rdata (b_rdata), .o_rvalid (b_rvalid), .o_ready (b_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] wa, input logic [15:0] wd, input logic [1:0] be);
    we = 1'b1; waddr = wa; wdata = wd; wbe = be;
    tick;
    we = 1'b0;
  endtask

  // Read (optionally with a same-cycle write), then follow both pipelines.
  task automatic rd_chk(input string tag, input logic [7:0] ra,
                        input logic [15:0] ea, input logic [15:0] eb,
                        input logic w, input logic [7:0] wa,
                        input logic [15:0] wd, input logic [1:0] be);
    we = w; waddr = wa; wdata = wd; wbe = be;
    re = 1'b1; raddr = ra;
    tick;
    we = 1'b0; re = 1'b0;
    chk({tag, "_a_early"}, a_rvalid, 1'b0);
    tick;
    chk({tag, "_a_valid"}, a_rvalid, 1'b1);
    chk({tag, "_a_data"},  a_rdata,  ea);
    chk({tag, "_b_early"}, b_rvalid, 1'b0);
    tick;
    chk({tag, "_a_pulse"}, a_rvalid, 1'b0);
    chk({tag, "_a_hold"},  a_rdata,  ea);
    chk({tag, "_b_valid"}, b_rvalid, 1'b1);
    chk({tag, "_b_data"},  b_rdata,  eb);
    tick;
    chk({tag, "_b_pulse"}, b_rvalid, 1'b0);
    chk({tag, "_b_hold"},  b_rdata,  eb);
  endtask

  // Counts edges from release until each o_ready rises; presents a read at edge 100.
  task automatic wait_ready(output int ea, output int eb, output int seen);
    ea = 0; eb = 0; seen = 0;
    for (int i = 1; i <= 400 && !(ea != 0 && eb != 0); i++) begin
      re = (i == 100);
      raddr = 8'd0;
      tick;
      if (a_ready && ea == 0) ea = i;
      if (b_ready && eb == 0) eb = i;
      if (a_rvalid || b_rvalid) seen = 1;
    end
    re = 1'b0;
  endtask

  logic [15:0] exp_seq [4];
  int          ea, eb, seen;

  initial begin
    rst_n = 1'b0; we = 1'b0; re = 1'b0;
    waddr = '0; raddr = '0; wdata = '0; wbe = '0;
    repeat (3) tick;
    chk("rst_a_ready",  a_ready,  1'b0);
    chk("rst_b_ready",  b_ready,  1'b0);
    chk("rst_a_rvalid", a_rvalid, 1'b0);
    chk("rst_b_rvalid", b_rvalid, 1'b0);
    chk("rst_a_rdata",  a_rdata,  16'h0000);
    chk("rst_b_rdata",  b_rdata,  16'h0000);
    rst_n = 1'b1;
    wait_ready(ea, eb, seen);
    chk("ready_edges_a", ea, READY_A);
    chk("ready_edges_b", eb, READY_B);
    chk("ready_no_rvalid", seen, 0);

    // byte-lane writes
    wr(8'd5, 16'hBEEF, 2'b11);
    wr(8'd5, 16'h1234, 2'b01);
    rd_chk("lane_lo", 8'd5, 16'hBE34, 16'hBE34, 1'b0, 8'd0, 16'h0, 2'b00);
    wr(8'd5, 16'h5678, 2'b10);
    rd_chk("lane_hi", 8'd5, 16'h5634, 16'h5634, 1'b0, 8'd0, 16'h0, 2'b00);
    wr(8'd5, 16'hFFFF, 2'b00);
    rd_chk("be_zero", 8'd5, 16'h5634, 16'h5634, 1'b0, 8'd0, 16'h0, 2'b00);

    // read during write, same address
    wr(8'd7, 16'h0055, 2'b11);
    rd_chk("rdw_full", 8'd7, 16'h0055, 16'h00AA, 1'b1, 8'd7, 16'h00AA, 2'b11);
    rd_chk("rdw_after", 8'd7, 16'h00AA, 16'h00AA, 1'b0, 8'd0, 16'h0, 2'b00);
    wr(8'd8, 16'h1111, 2'b11);
    rd_chk("rdw_part", 8'd8, 16'h1111, 16'h1122, 1'b1, 8'd8, 16'h2222, 2'b01);

    // beyond DEPTH on the 200-word instance
    wr(8'd210, 16'h0077, 2'b11);
    rd_chk("oor", 8'd210, 16'h0000, 16'h0077, 1'b0, 8'd0, 16'h0, 2'b00);

    // four back-to-back reads
    wr(8'd3, 16'h0303, 2'b11);
    wr(8'd4, 16'h0404, 2'b11);
    wr(8'd6, 16'h0606, 2'b11);
    exp_seq[0] = 16'h0303; exp_seq[1] = 16'h0404;
    exp_seq[2] = 16'h5634; exp_seq[3] = 16'h0606;
    for (int c = 0; c < 7; c++) begin
      re = (c < 4);
      raddr = 8'd3 + 8'(c);
      tick;
      chk("b2b_a_valid", a_rvalid, (c >= 1 && c <= 4));
      if (c >= 1 && c <= 4) chk("b2b_a_data", a_rdata, exp_seq[c-1]);
      chk("b2b_b_valid", b_rvalid, (c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) chk("b2b_b_data", b_rdata, exp_seq[c-2]);
    end
    re = 1'b0;

`ifndef SRAM_SDP_CLEAR_EN
    // reset with a read in flight, then requests while o_ready is still low
    wr(8'd9, 16'h0909, 2'b11);
    re = 1'b1; raddr = 8'd3;
    tick;
    re = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_a_rvalid", a_rvalid, 1'b0);
    chk("mid_rst_b_rvalid", b_rvalid, 1'b0);
    chk("mid_rst_a_rdata",  a_rdata,  16'h0000);
    chk("mid_rst_b_rdata",  b_rdata,  16'h0000);
    chk("mid_rst_ready",    a_ready,  1'b0);
    tick;
    rst_n = 1'b1;
    we = 1'b1; waddr = 8'd9; wdata = 16'h9999; wbe = 2'b11;
    re = 1'b1; raddr = 8'd9;
    tick;
    we = 1'b0; re = 1'b0;
    chk("rerelease_ready", a_ready, 1'b1);
    seen = 0;
    repeat (4) begin
      tick;
      if (a_rvalid || b_rvalid) seen = 1;
    end
    chk("notready_no_rvalid", seen, 0);
    rd_chk("notready_no_write", 8'd9, 16'h0909, 16'h0909, 1'b0, 8'd0, 16'h0, 2'b00);
`else
    // reset during the sweep restarts it
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    repeat (50) tick;
    rst_n = 1'b0;
    tick;
    chk("clr_rst_ready", b_ready, 1'b0);
    rst_n = 1'b1;
    wait_ready(ea, eb, seen);
    chk("clr_restart_edges_a", ea, READY_A);
    chk("clr_restart_edges_b", eb, READY_B);
    chk("clr_read_ignored", seen, 0);
    begin
      int          cnt_a, cnt_b;
      logic [15:0] or_a, or_b;
      cnt_a = 0; cnt_b = 0; or_a = '0; or_b = '0;
      for (int c = 0; c < 260; c++) begin
        re = (c < 256);
        raddr = 8'(c);
        tick;
        if (a_rvalid) begin cnt_a++; or_a |= a_rdata; end
        if (b_rvalid) begin cnt_b++; or_b |= b_rdata; end
      end
      re = 1'b0;
      chk("clr_cnt_a", cnt_a, 256);
      chk("clr_cnt_b", cnt_b, 256);
      chk("clr_zero_a", or_a, 16'h0000);
      chk("clr_zero_b", or_b, 16'h0000);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
